// File: rtl/reg_file_wr_arb.sv
// ---------------------------------------------------------------------------
// reg_file_wr_arb
//
// Purpose:
//   Two-requester write-port arbiter in front of the 4 x 16-bit register
//   file. Each requester hands over one write (address + data) into its own
//   1-deep holding slot. The slots are drained round-robin onto the single
//   registered write port (wr_en / w_addr / w_data), at most one write per
//   cycle.
//
// Handshake (both requesters):
//   reqK_ready is high exactly when slot K is empty. It is a pure register
//   output with no combinational path from reqK_valid. A transfer happens on a
//   rising clk edge where reqK_valid & reqK_ready. A slot that is being
//   drained at an edge shows ready low during that cycle, so it is never
//   reloaded at the same edge.
//
// Optional feature:
//   RFARB_STATS_EN - when defined, adds the conflict_cnt output. This is a
//                    saturating 8-bit count of cycles in which both slots
//                    are full.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   req0_valid    in   requester 0 has a write to hand over
//   req0_ready    out  requester 0 slot empty
//   req0_addr     in   requester 0 target register  [ADDR_W]
//   req0_data     in   requester 0 write data       [DATA_W]
//   req1_*             same for requester 1
//   wr_en         out  registered write strobe to the register file
//   w_addr        out  registered write address (holds while wr_en=0)
//   w_data        out  registered write data    (holds while wr_en=0)
//   busy          out  any slot full or wr_en high
//   conflict_cnt  out  contention counter (RFARB_STATS_EN only)
//   dbg_state     out  FSM state (0 = IDLE, 1 = WRITE)
// ---------------------------------------------------------------------------
module reg_file_wr_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              busy,
`ifdef RFARB_STATS_EN
  output logic [7:0]        conflict_cnt,
`endif
  output logic              dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic              full0_q, full0_d;
  logic              full1_q, full1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              prio_q, prio_d;

  logic any_full;
  logic both_full;
  logic gnt0;
  logic gnt1;
  logic acc0;
  logic acc1;

  // Grant decision on the current slot flags. A lone full slot always wins.
  // When both slots are full, prio names the winner.
  always_comb begin
    any_full  = full0_q | full1_q;
    both_full = full0_q & full1_q;
    gnt0      = full0_q & (~full1_q | ~prio_q);
    gnt1      = full1_q & (~full0_q |  prio_q);
    acc0      = req0_valid & ~full0_q;
    acc1      = req1_valid & ~full1_q;
  end

  // Slot, write-port and pointer next state. Accept and drain of the same
  // slot are mutually exclusive: a slot can only be accepted into when empty,
  // and it can only be drained when full.
  always_comb begin
    full0_d  = full0_q;
    full1_d  = full1_q;
    addr0_d  = addr0_q;
    addr1_d  = addr1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    prio_d   = prio_q;

    if (acc0) begin
      full0_d = 1'b1;
      addr0_d = req0_addr;
      data0_d = req0_data;
    end
    if (acc1) begin
      full1_d = 1'b1;
      addr1_d = req1_addr;
      data1_d = req1_data;
    end

    if (gnt0) begin
      full0_d  = 1'b0;
      w_addr_d = addr0_q;
      w_data_d = data0_q;
      prio_d   = 1'b1;
    end else if (gnt1) begin
      full1_d  = 1'b0;
      w_addr_d = addr1_q;
      w_data_d = data1_q;
      prio_d   = 1'b0;
    end
  end

  // The FSM state is the write strobe. WRITE is held for as long as a slot is
  // full at each edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_full)  state_d = ST_WRITE;
      ST_WRITE: if (!any_full) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full0_q  <= 1'b0;
      full1_q  <= 1'b0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      prio_q   <= 1'b0;
    end else begin
      full0_q  <= full0_d;
      full1_q  <= full1_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      prio_q   <= prio_d;
    end
  end

`ifdef RFARB_STATS_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (both_full && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  // Contention is only observed when the stats counter is built.
  logic unused_both_full;
  assign unused_both_full = both_full;
`endif

  assign req0_ready = ~full0_q;
  assign req1_ready = ~full1_q;
  assign wr_en      = (state_q == ST_WRITE);
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign busy       = full0_q | full1_q | wr_en;
  assign dbg_state  = state_q;

endmodule
